// File: rtl/pipe_result_checker.sv
// ---------------------------------------------------------------------------
// pipe_result_checker
//
// Last stage of the encoder -> ALU -> parity-generator pipeline. It takes the
// parity-tagged ALU result word, checks its parity, and buffers the data in a
// small FIFO. The next consumer reads the FIFO through a valid/ready
// handshake. Each stored entry keeps its own parity-failure flag, and a
// saturating counter records how many bad words were accepted.
//
// Parameters
//   DATA_W      ALU result width; the input word is DATA_W+1 bits wide
//   DEPTH       FIFO entries (power of two, >= 2)
//   ODD_PARITY  0 = even parity expected, 1 = odd parity expected
//   ERR_CNT_W   width of the parity-error counter
//
// Ports
//   clk        clock; all state updates on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   upstream word valid
//   in_ready   block can accept a word this cycle
//   in_word    {data[DATA_W-1:0], parity}; parity is bit 0
//   out_valid  head entry available
//   out_ready  downstream accepts the head entry
//   out_data   head entry data (0 when empty)
//   out_perr   head entry failed the parity check (0 when empty)
//   err_count  saturating count of accepted words with bad parity
//   count      current occupancy
//   full       count == DEPTH
//   empty      count == 0
//
// Build option
//   PIPE_CHK_DROP_BAD_EN  when defined, words with bad parity are still
//                         accepted and counted, but are not written to the
//                         FIFO, and out_perr is tied to 0.
// ---------------------------------------------------------------------------
module pipe_result_checker #(
  parameter int DATA_W     = 4,
  parameter int DEPTH      = 4,
  parameter int ODD_PARITY = 0,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W:0]          in_word,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_perr,
  output logic [ERR_CNT_W-1:0]     err_count,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic PARITY_SENSE = (ODD_PARITY != 0);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] mem_data [DEPTH];

  logic bad;
  logic push;
  logic pop;
  logic store;

  // A word is bad when the XOR over all of its bits differs from the
  // expected parity sense.
  assign bad = ((^in_word) != PARITY_SENSE);

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign out_valid = !empty;

  // No bypass: a full FIFO refuses a push even if a pop happens in the same
  // cycle. in_ready is also held low while reset is asserted.
  assign in_ready = rst_n && !full;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

`ifdef PIPE_CHK_DROP_BAD_EN
  // Bad words complete the handshake but never reach the buffer.
  assign store = push && !bad;
`else
  logic mem_perr [DEPTH];

  assign store = push;
`endif

  // Pointers, occupancy and the error counter. Reset takes priority over any
  // push or pop presented in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      err_count <= '0;
    end else begin
      if (store) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({store, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // Saturate rather than wrap so a long run of errors stays visible.
      if (push && bad && (err_count != ERR_MAX)) begin
        err_count <= err_count + ERR_CNT_W'(1);
      end
    end
  end

  // Storage array; entries need no reset because the outputs are forced to
  // zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (rst_n && store) begin
      mem_data[wr_ptr] <= in_word[DATA_W:1];
`ifndef PIPE_CHK_DROP_BAD_EN
      mem_perr[wr_ptr] <= bad;
`endif
    end
  end

  // Head entry presentation. The head only moves on a pop, so it stays
  // stable while out_valid is high and out_ready is low.
  always_comb begin
    out_data = '0;
    out_perr = 1'b0;
    if (!empty) begin
      out_data = mem_data[rd_ptr];
`ifndef PIPE_CHK_DROP_BAD_EN
      out_perr = mem_perr[rd_ptr];
`endif
    end
  end

endmodule

// File: doc/pipe_result_checker.md
Name: pipe_result_checker

Overview:
Downstream stage of the encoder -> ALU -> parity-generator pipeline. It consumes the 5-bit parity-tagged ALU result word, checks its parity, and buffers the data in a small FIFO. Results are presented to the next consumer through a valid/ready handshake. Parity failures are flagged per entry and counted in a saturating error counter.

Parameters:
- DATA_W, 4, ALU result width. Input word is DATA_W+1 bits.
- DEPTH, 4, FIFO entries. Must be a power of 2, >= 2.
- ODD_PARITY, 0, parity sense. 0 = even (XOR of all DATA_W+1 bits must be 0); 1 = odd (XOR must be 1).
- ERR_CNT_W, 8, width of the parity-error counter.

Ports:
- clk, input, 1, clock. All state updates on the rising edge.
- rst_n, input, 1, reset: synchronous, active-low.
- in_valid, input, 1, upstream word valid.
- in_ready, output, 1, block can accept a word this cycle.
- in_word, input, DATA_W+1, {data[DATA_W-1:0], parity}. Parity is bit 0, data is bits [DATA_W:1].
- out_valid, output, 1, head entry available.
- out_ready, input, 1, downstream accepts head entry.
- out_data, output, DATA_W, head entry data.
- out_perr, output, 1, head entry failed the parity check.
- err_count, output, ERR_CNT_W, saturating count of parity failures seen.
- count, output, $clog2(DEPTH)+1, current occupancy.
- full, output, 1, count == DEPTH.
- empty, output, 1, count == 0.

Behaviour:
- Reset: rst_n sampled low at a rising edge clears the following.
  - Read and write pointers, count, and err_count go to 0.
  - Outputs: out_valid=0, out_data=0, out_perr=0, empty=1, full=0, in_ready=1 (in_ready stays 0 while rst_n is low).
  - Reset mid-operation discards all buffered entries. Any push or pop in that cycle is ignored.
- Parity check is combinational on in_word: bad = (^in_word) != ODD_PARITY.
- Push: in_valid && in_ready at a rising edge.
  - {data, bad} is written at the write pointer.
  - Write pointer increments modulo DEPTH.
- Pop: out_valid && out_ready at a rising edge.
  - Read pointer increments modulo DEPTH.
- in_ready = !full. There is no bypass, so a push is refused when full even if a pop occurs that cycle.
- Simultaneous push and pop when not full and not empty: both occur and count is unchanged.
- Push when empty: nothing is popped that cycle.
- Latency: a word accepted at edge N gives out_valid=1 with its data after edge N (registered). There is no same-cycle pass-through.
- out_valid = !empty.
- out_data and out_perr are driven from the head entry. When empty, both hold 0.
- Head entry stability: while out_valid && !out_ready, out_data and out_perr must not change.
- count update per edge: +1 on push only, -1 on pop only, unchanged otherwise.
- full and empty are derived from count, so they are valid in the same cycle.
- Pointer wrap-around at DEPTH-1 -> 0 must not corrupt ordering. Output order is strict FIFO.
- err_count increments by 1 on every accepted push with bad=1.
  - It saturates at 2^ERR_CNT_W-1 and never wraps.
  - It is cleared only by reset.
- in_valid with !in_ready: the word is not accepted and not counted. Upstream must hold it.

Optional Feature:
- Macro: PIPE_CHK_DROP_BAD_EN.
- Defined:
  - Words failing parity are still accepted (in_ready unchanged) and counted in err_count.
  - They are not written to the FIFO, and pointers and count are unchanged.
  - out_perr is tied to 0.
- Undefined: bad words are stored with out_perr=1, as above.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with in_valid=1 -> after release count=0, empty=1, out_valid=0, err_count=0, in_ready=1.
- Good words, even parity:
  - Push 5'b01100 (data 0110) then 5'b10111 (data 1011), out_ready=1.
  - Required: out_data 0110 then 1011, each one edge after its push, out_perr=0, err_count=0.
- Bad word:
  - Push 5'b10110 -> out_data=1011, out_perr=1, err_count=1.
  - With PIPE_CHK_DROP_BAD_EN: out_valid stays 0, err_count=1.
- Full and backpressure, DEPTH=4, out_ready=0:
  - Push 5 words -> full=1, in_ready=0 after the 4th.
  - The 5th word is not stored. Then raise out_ready -> 4 words drain in order, empty=1.
- Wrap and simultaneous push/pop:
  - Stream 10 good words with out_ready=1 throughout -> count stays at 1 in steady state, order preserved across pointer wrap, no loss.
- Saturation: ERR_CNT_W=2, push 5 bad words -> err_count = 3, 3, 3 after the 3rd, 4th and 5th pushes; never returns to 0.
